tx_skp_os_inserter: RTL

- Transmit-side SKP ordered-set generator. It is the counterpart of the receive elastic buffer write-pointer logic, which adds or deletes SKP symbols to absorb clock offset.
- It sits before the 8b/10b encoder and periodically inserts COM + SKP_COUNT × SKP into the outgoing symbol stream.
- Insertion happens only at packet boundaries. The upstream link layer is stalled through a ready handshake while a set is sent.
- SKP_SYMBOL encodes to 10'b001111_1001 / 10'b110000_0110, the exact pair the receive buffer detects.

---
 rtl/tx_skp_os_inserter.sv | 114 +++++++++++
 1 files changed

// File: rtl/tx_skp_os_inserter.sv
// Transmit-side SKP ordered-set inserter. It sits ahead of the 8b/10b encoder and periodically
// emits COM + SKP_COUNT x SKP, but only at packet boundaries, stalling upstream through in_ready.
module tx_skp_os_inserter #(
    parameter int          SKP_INTERVAL = 1180,
    parameter int          SKP_COUNT    = 3,
    parameter logic [7:0]  COM_SYMBOL   = 8'hBC,
    parameter logic [7:0]  SKP_SYMBOL   = 8'h3C,
    parameter logic [7:0]  IDLE_SYMBOL  = 8'h00
) (
    input  logic       write_clk,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic [7:0] data_in,
    input  logic       k_in,
    input  logic       in_valid,
    input  logic       in_sop,
    output logic       in_ready,
    input  logic       force_skp,
    output logic [7:0] data_out,
    output logic       k_out,
    output logic       skp_active,
    output logic       skp_sent,
    output logic       skp_overrun
);

    localparam int               CNT_W    = $clog2(SKP_INTERVAL);
    localparam logic [CNT_W-1:0] TC_VALUE = CNT_W'(SKP_INTERVAL - 1);
    localparam logic [2:0]       SKP_LAST = 3'(SKP_COUNT - 1);

    typedef enum logic {
        PASS,
        SKP_OS
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] interval_cnt;
    logic             pending;
    logic [2:0]       skp_cnt;
    logic             tc;
    logic             start;

    assign tc    = tx_en && (interval_cnt == TC_VALUE);
    // A set may only begin when no packet is in flight: either a gap or a fresh sop symbol.
    assign start = (state == PASS) && pending && (!in_valid || in_sop);

    // NOTE: in_ready is combinational so that a sop symbol that triggers an insertion is held
    // back in the same cycle; gating with rst_n keeps upstream stalled while in reset.
    assign in_ready = rst_n && (state == PASS) && !start;

    // Interval scheduling keeps running through insertions; a request stays pending until serviced.
    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge write_clk or negedge rst_n) begin
        if (!rst_n) begin
            interval_cnt <= '0;
            pending      <= 1'b0;
            skp_overrun  <= 1'b0;
        end else begin
            if (tx_en) begin
                interval_cnt <= tc ? '0 : interval_cnt + CNT_W'(1);
                pending      <= (pending && !start) || tc || force_skp;
            end else begin
                interval_cnt <= '0;
                pending      <= 1'b0;
            end
            skp_overrun <= tc && pending && !start;
        end
    end

    // Output path: pass-through with one cycle of latency, or the ordered set when inserting.
    always_ff @(posedge write_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PASS;
            data_out   <= IDLE_SYMBOL;
            k_out      <= 1'b0;
            skp_active <= 1'b0;
            skp_sent   <= 1'b0;
            skp_cnt    <= '0;
        end else begin
            skp_sent <= 1'b0;
            case (state)
                PASS: begin
                    if (start) begin
                        data_out   <= COM_SYMBOL;
                        k_out      <= 1'b1;
                        skp_active <= 1'b1;
                        skp_cnt    <= '0;
                        state      <= SKP_OS;
                    end else if (in_valid) begin
                        data_out   <= data_in;
                        k_out      <= k_in;
                        skp_active <= 1'b0;
                    end else begin
                        data_out   <= IDLE_SYMBOL;
                        k_out      <= 1'b0;
                        skp_active <= 1'b0;
                    end
                end
                SKP_OS: begin
                    // The set always runs to completion, independent of tx_en.
                    data_out   <= SKP_SYMBOL;
                    k_out      <= 1'b1;
                    skp_active <= 1'b1;
                    skp_cnt    <= skp_cnt + 3'd1;
                    if (skp_cnt == SKP_LAST) begin
                        skp_sent <= 1'b1;
                        state    <= PASS;
                    end
                end
                default: state <= PASS;
            endcase
        end
    end

endmodule
